stream_arb_2to1: RTL and testbench

//   Round-robin arbiter feeding a 2:1 datapath mux. Arbitrates two valid/ready source

---
 rtl/stream_arb_2to1.sv | 129 ++++++++++++
 tb/tb_stream_arb_2to1.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb_2to1.sv
// stream_arb_2to1
//   Round-robin arbiter for two valid/ready source streams. The winning word goes
//   into a single registered output slot. out_sel records which source supplied
//   the word, so it can drive the select of a downstream 2:1 datapath mux.
//
//   Optional feature: define ARB_PKT_LOCK_EN to enable packet locking. This adds
//   in0_last, in1_last and out_last. A multi-beat packet then holds the grant on
//   its source until its last beat has been accepted.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in0_valid  in   1      source 0 has a word
//   in0_ready  out  1      source 0 word accepted this cycle
//   in0_data   in   WIDTH  source 0 payload
//   in0_last   in   1      (ARB_PKT_LOCK_EN) last beat of a source 0 packet
//   in1_valid  in   1      source 1 has a word
//   in1_ready  out  1      source 1 word accepted this cycle
//   in1_data   in   WIDTH  source 1 payload
//   in1_last   in   1      (ARB_PKT_LOCK_EN) last beat of a source 1 packet
//   out_valid  out  1      output slot holds a word
//   out_ready  in   1      sink takes the word this cycle
//   out_data   out  WIDTH  registered payload
//   out_sel    out  1      source of out_data (0 = in0, 1 = in1)
//   out_last   out  1      (ARB_PKT_LOCK_EN) registered last flag
module stream_arb_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
`ifdef ARB_PKT_LOCK_EN
  input  logic             in0_last,
  input  logic             in1_last,
  output logic             out_last,
`endif
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel
);

  // prio names the source that wins when both sources are valid.
  logic       prio;
  logic       load;
  logic [1:0] grant;
  logic       take0;
  logic       take1;

`ifdef ARB_PKT_LOCK_EN
  logic lock;
  logic lock_id;
  logic take_last;
`endif

  always_comb begin
    // NOTE: every signal gets a default at the top of the block. Without it, a path
    // that skips an assignment infers a latch.
    grant = 2'b00;
    // The slot can accept a word when it is empty or is being drained on this edge.
    load  = ~out_valid | out_ready;

    if (in0_valid && in1_valid) begin
      grant = prio ? 2'b10 : 2'b01;
    end else begin
      grant = {in1_valid, in0_valid};
    end

`ifdef ARB_PKT_LOCK_EN
    // While a packet is in flight, only its own source can win.
    if (lock) begin
      grant = lock_id ? {in1_valid, 1'b0} : {1'b0, in0_valid};
    end
`endif

    // Hold both ready signals low during reset, so no word is accepted on a reset edge.
    in0_ready = ~rst & load & grant[0];
    in1_ready = ~rst & load & grant[1];
    take0     = in0_valid & in0_ready;
    take1     = in1_valid & in1_ready;
`ifdef ARB_PKT_LOCK_EN
    take_last = take1 ? in1_last : in0_last;
`endif
  end

  // NOTE: state updates use non-blocking assignments. Every register then sees the
  // pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the payload registers are reset as well. A reset leaves a
      // deterministic, known-zero word, not the remains of a discarded one.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
      prio      <= 1'b0;
`ifdef ARB_PKT_LOCK_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
      lock_id   <= 1'b0;
`endif
    end else if (take0 || take1) begin
      out_valid <= 1'b1;
      out_data  <= take1 ? in1_data : in0_data;
      out_sel   <= take1;
`ifdef ARB_PKT_LOCK_EN
      out_last  <= take_last;
      if (take_last) begin
        lock <= 1'b0;
        prio <= ~take1;
      end else begin
        // prio stays put mid-packet. It rotates only once the packet ends.
        lock    <= 1'b1;
        lock_id <= take1;
      end
`else
      prio      <= ~take1;
`endif
    end else if (out_ready) begin
      // The slot drained and nothing replaced it. The payload keeps its last value.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb_2to1.sv
// tb_stream_arb_2to1
//   Directed bench for stream_arb_2to1. Drivers push the expected output words into
//   exp_q. The monitor pops and compares one entry on every output transfer.
module tb_stream_arb_2to1;

  typedef struct {
    logic [7:0] data;
    logic       sel;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } src_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in0_ready, in1_valid, in1_ready;
  logic [7:0] in0_data, in1_data, out_data;
  logic       in0_last, in1_last;
  logic       out_valid, out_ready, out_sel;
`ifdef ARB_PKT_LOCK_EN
  logic       out_last;
`else
  logic       out_last = 1'b0;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  src_t src0[$];
  src_t src1[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  stream_arb_2to1 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in0_valid(in0_valid),
    .in0_ready(in0_ready),
    .in0_data (in0_data),
`ifdef ARB_PKT_LOCK_EN
    .in0_last (in0_last),
    .in1_last (in1_last),
    .out_last (out_last),
`endif
    .in1_valid(in1_valid),
    .in1_ready(in1_ready),
    .in1_data (in1_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: runs on the falling edge, away from the active rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("ready_one_hot", {31'd0, in0_ready & in1_ready}, 0);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data %0h sel %0b with nothing expected",
                   out_data, out_sel);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, mon_e.data});
          check("out_sel", {31'd0, out_sel}, {31'd0, mon_e.sel});
`ifdef ARB_PKT_LOCK_EN
          check("out_last", {31'd0, out_last}, {31'd0, mon_e.last});
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic push_exp(input logic [7:0] d, input logic s, input logic l);
    exp_t e;
    e.data = d;
    e.sel  = s;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_src(input logic n, input logic [7:0] d, input logic l);
    src_t s;
    s.data = d;
    s.last = l;
    if (n) src1.push_back(s);
    else   src0.push_back(s);
  endtask

  // Present the words queued in src0/src1. Each word is retired once its ready is seen.
  task automatic run(input int budget);
    int   n = 0;
    logic t0, t1;
    while ((src0.size() > 0 || src1.size() > 0) && n < budget) begin
      in0_valid = (src0.size() > 0);
      in1_valid = (src1.size() > 0);
      if (in0_valid) begin
        in0_data = src0[0].data;
        in0_last = src0[0].last;
      end
      if (in1_valid) begin
        in1_data = src1[0].data;
        in1_last = src1[0].last;
      end
      @(negedge clk);
      t0 = in0_valid & in0_ready;
      t1 = in1_valid & in1_ready;
      step();
      if (t0) void'(src0.pop_front());
      if (t1) void'(src1.pop_front());
      n++;
    end
    check("run_complete", src0.size() + src1.size(), 0);
    src0.delete();
    src1.delete();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_last  = 1'b1;
    in1_last  = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 8'h5A;
    in1_data  = 8'hA5;
    in0_last  = 1'b1;
    in1_last  = 1'b1;
    out_ready = 1'b1;

    // Reset with both sources valid.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_in0_ready", {31'd0, in0_ready}, 0);
      check("rst_in1_ready", {31'd0, in1_ready}, 0);
      check("rst_out_sel", {31'd0, out_sel}, 0);
    end
    step();
    rst = 1'b0;
    idle(1);

    // Single source, three back-to-back words, one cycle of latency each.
    push_exp(8'h11, 1'b0, 1'b1);
    push_exp(8'h22, 1'b0, 1'b1);
    push_exp(8'h33, 1'b0, 1'b1);
    in0_valid = 1'b1;
    in0_data  = 8'h11;
    @(negedge clk);
    check("t2_accept_11", {31'd0, in0_ready}, 1);
    step();
    in0_data = 8'h22;
    @(negedge clk);
    check("t2_latency_11", {31'd0, out_valid}, 1);
    check("t2_accept_22", {31'd0, in0_ready}, 1);
    step();
    in0_data = 8'h33;
    @(negedge clk);
    check("t2_latency_22", {31'd0, out_valid}, 1);
    check("t2_accept_33", {31'd0, in0_ready}, 1);
    step();
    idle(3);
    check("t2_drained", exp_q.size(), 0);

    // Contention: starting from reset priority, grants alternate 0,1,0,1.
    pulse_reset();
    push_src(1'b0, 8'hA0, 1'b1);
    push_src(1'b0, 8'hA1, 1'b1);
    push_src(1'b1, 8'hB0, 1'b1);
    push_src(1'b1, 8'hB1, 1'b1);
    push_exp(8'hA0, 1'b0, 1'b1);
    push_exp(8'hB0, 1'b1, 1'b1);
    push_exp(8'hA1, 1'b0, 1'b1);
    push_exp(8'hB1, 1'b1, 1'b1);
    run(20);
    idle(3);
    check("t3_drained", exp_q.size(), 0);

    // Backpressure: the full slot holds for 5 cycles, then drains and loads on one edge.
    push_exp(8'h44, 1'b0, 1'b1);
    push_exp(8'h55, 1'b1, 1'b1);
    out_ready = 1'b0;
    in0_valid = 1'b1;
    in0_data  = 8'h44;
    @(negedge clk);
    check("t4_accept_44", {31'd0, in0_ready}, 1);
    step();
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 8'h55;
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, out_valid}, 1);
      check("t4_hold_data", {24'd0, out_data}, 32'h44);
      check("t4_hold_sel", {31'd0, out_sel}, 0);
      check("t4_hold_in0_ready", {31'd0, in0_ready}, 0);
      check("t4_hold_in1_ready", {31'd0, in1_ready}, 0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_load_on_drain", {31'd0, in1_ready}, 1);
    step();
    in1_valid = 1'b0;
    @(negedge clk);
    check("t4_no_bubble", {31'd0, out_valid}, 1);
    step();
    idle(2);
    check("t4_drained", exp_q.size(), 0);

    // Reset during a stall: the held word is discarded, and nothing is accepted on the reset edge.
    out_ready = 1'b0;
    in0_valid = 1'b1;
    in0_data  = 8'h66;
    @(negedge clk);
    check("t5_accept_66", {31'd0, in0_ready}, 1);
    step();
    in0_valid = 1'b0;
    step();
    @(negedge clk);
    check("t5_slot_full", {31'd0, out_valid}, 1);
    step();
    rst       = 1'b1;
    in1_valid = 1'b1;
    in1_data  = 8'h77;
    @(negedge clk);
    check("t5_rst_in1_ready", {31'd0, in1_ready}, 0);
    step();
    rst       = 1'b0;
    in1_valid = 1'b0;
    @(negedge clk);
    check("t5_rst_out_valid", {31'd0, out_valid}, 0);
    check("t5_rst_out_data", {24'd0, out_data}, 0);
    step();
    out_ready = 1'b1;
    idle(4);
    check("t5_nothing_out", exp_q.size(), 0);

`ifdef ARB_PKT_LOCK_EN
    // Packet lock: in1 keeps the grant for its 3-beat packet while in0 waits.
    pulse_reset();
    push_src(1'b0, 8'hA9, 1'b1);
    push_exp(8'hA9, 1'b0, 1'b1);
    run(10);
    push_src(1'b1, 8'hB0, 1'b0);
    push_src(1'b1, 8'hB1, 1'b0);
    push_src(1'b1, 8'hB2, 1'b1);
    push_src(1'b0, 8'hA0, 1'b1);
    push_exp(8'hB0, 1'b1, 1'b0);
    push_exp(8'hB1, 1'b1, 1'b0);
    push_exp(8'hB2, 1'b1, 1'b1);
    push_exp(8'hA0, 1'b0, 1'b1);
    run(20);
    idle(3);
    check("t6_drained", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
